// File: rtl/calc1_req_sequencer.sv
// Host-side request sequencer for one calculator channel: buffers {cmd,op1,op2} in a FIFO and
// issues one request at a time. Define CALC1_SEQ_TIMEOUT_EN to enable the WAIT-state timeout.
module calc1_req_sequencer #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 10
) (
  input  logic        c_clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_cmd,
  input  logic [31:0] in_op1,
  input  logic [31:0] in_op2,
  output logic [3:0]  req_cmd_out,
  output logic [31:0] req_data_out,
  input  logic [1:0]  out_resp,
  input  logic [31:0] out_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [1:0]  rsp_resp,
  output logic [31:0] rsp_data,
  output logic [3:0]  rsp_cmd,
  output logic        rsp_timeout,
  output logic        busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = 1;

  typedef enum logic [2:0] {S_IDLE, S_SEND1, S_SEND2, S_WAIT, S_HOLD} state_t;

  state_t         r_state, w_state_next;
  logic [67:0]    r_mem [FIFO_DEPTH];
  logic [PTR_W:0] r_wr_ptr, r_rd_ptr;
  logic [3:0]     r_cur_cmd;
  logic [31:0]    r_cur_op1, r_cur_op2;
  logic [1:0]     r_rsp_resp;
  logic [31:0]    r_rsp_data;
  logic [3:0]     r_rsp_cmd;
  logic           w_empty, w_full, w_push, w_pop, w_capture, w_timeout_hit;
  logic [1:0]     w_cap_resp;
  logic [31:0]    w_cap_data;

  // Extra pointer MSB distinguishes full from empty when the index bits match
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                   (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
  assign in_ready = !w_full;
  assign w_push   = in_valid && in_ready && !reset;

  assign rsp_valid = (r_state == S_HOLD);
  assign rsp_resp  = r_rsp_resp;
  assign rsp_data  = r_rsp_data;
  assign rsp_cmd   = r_rsp_cmd;
  assign busy      = (r_state != S_IDLE) || !w_empty;

`ifdef CALC1_SEQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_wait_cnt;
  logic             r_rsp_timeout;

  // Counter holds k-1 during the k-th WAIT cycle
  assign w_timeout_hit = (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign rsp_timeout   = r_rsp_timeout;

  always_ff @(posedge c_clk) begin
    if (reset || r_state != S_WAIT) r_wait_cnt <= '0;
    else                            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
    if (reset) r_rsp_timeout <= 1'b0;
    else if (w_capture) r_rsp_timeout <= (r_state == S_WAIT) && (out_resp == 2'b00);
  end
`else
  assign w_timeout_hit = 1'b0;
  assign rsp_timeout   = 1'b0;
`endif

  always_ff @(posedge c_clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    w_capture    = 1'b0;
    w_cap_resp   = 2'b00;
    w_cap_data   = '0;
    req_cmd_out  = '0;
    req_data_out = '0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_state_next = S_SEND1;
        end
      end
      S_SEND1: begin
        req_cmd_out  = r_cur_cmd;
        req_data_out = r_cur_op1;
        w_state_next = S_SEND2;
      end
      S_SEND2: begin
        req_data_out = r_cur_op2;
        // A no-op command never gets a calculator answer, so complete it locally
        if (r_cur_cmd == 4'd0) begin
          w_capture    = 1'b1;
          w_state_next = S_HOLD;
        end else begin
          w_state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (out_resp != 2'b00) begin
          w_capture    = 1'b1;
          w_cap_resp   = out_resp;
          w_cap_data   = out_data;
          w_state_next = S_HOLD;
        end else if (w_timeout_hit) begin
          w_capture    = 1'b1;
          w_state_next = S_HOLD;
        end
      end
      S_HOLD: begin
        if (rsp_ready) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge c_clk) begin
    if (w_push) r_mem[r_wr_ptr[PTR_W-1:0]] <= {in_cmd, in_op1, in_op2};
  end

  always_ff @(posedge c_clk) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_cur_cmd  <= '0;
      r_cur_op1  <= '0;
      r_cur_op2  <= '0;
      r_rsp_resp <= '0;
      r_rsp_data <= '0;
      r_rsp_cmd  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
        {r_cur_cmd, r_cur_op1, r_cur_op2} <= r_mem[r_rd_ptr[PTR_W-1:0]];
      end
      if (w_capture) begin
        r_rsp_resp <= w_cap_resp;
        r_rsp_data <= w_cap_data;
        r_rsp_cmd  <= r_cur_cmd;
      end
    end
  end

endmodule

// File: tb/tb_calc1_req_sequencer.sv
// Scoreboard bench for calc1_req_sequencer with a small calculator-channel responder model.
module tb_calc1_req_sequencer;

  logic        c_clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_cmd = '0;
  logic [31:0] in_op1 = '0;
  logic [31:0] in_op2 = '0;
  logic [3:0]  req_cmd_out;
  logic [31:0] req_data_out;
  logic [1:0]  out_resp = '0;
  logic [31:0] out_data = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [1:0]  rsp_resp;
  logic [31:0] rsp_data;
  logic [3:0]  rsp_cmd;
  logic        rsp_timeout;
  logic        busy;

  calc1_req_sequencer #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(10)) dut (
    .c_clk(c_clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_cmd(in_cmd), .in_op1(in_op1), .in_op2(in_op2),
    .req_cmd_out(req_cmd_out), .req_data_out(req_data_out),
    .out_resp(out_resp), .out_data(out_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_resp(rsp_resp),
    .rsp_data(rsp_data), .rsp_cmd(rsp_cmd), .rsp_timeout(rsp_timeout), .busy(busy)
  );

  always #5 c_clk = ~c_clk;

  typedef struct {
    logic [3:0]  cmd;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [1:0]  resp;
    logic [31:0] data;
    int          delay;  // WAIT cycle in which the model answers; <=0 never answers
  } model_t;

  typedef struct {
    logic [1:0]  resp;
    logic [31:0] data;
    logic [3:0]  cmd;
    logic        timeout;
  } exp_t;

  model_t model_q[$];
  exp_t   sb_q[$];
  int     n_checks = 0;
  int     n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic add_model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                           input logic [1:0] r, input logic [31:0] d, input int dly);
    model_t m;
    m.cmd = c; m.op1 = a; m.op2 = b; m.resp = r; m.data = d; m.delay = dly;
    model_q.push_back(m);
  endtask

  task automatic add_sb(input logic [1:0] r, input logic [31:0] d, input logic [3:0] c,
                        input logic t);
    exp_t e;
    e.resp = r; e.data = d; e.cmd = c; e.timeout = t;
    sb_q.push_back(e);
  endtask

  // Called #1 after a posedge; returns #1 after the acceptance edge
  task automatic push(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    int k;
    in_valid = 1'b1; in_cmd = c; in_op1 = a; in_op2 = b;
    k = 0;
    while (!in_ready && k < 200) begin
      @(posedge c_clk); #1;
      k++;
    end
    chk("push_accept", 32'(in_ready), 32'd1);
    if (in_ready) begin
      @(posedge c_clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] r, input logic [31:0] d, input int dly);
    if (c != 4'd0) add_model(c, a, b, r, d, dly);
    add_sb(r, d, c, 1'b0);
    push(c, a, b);
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while ((busy || sb_q.size() != 0) && k < 300) begin
      @(posedge c_clk); #1;
      k++;
    end
    chk(name, 32'(busy || sb_q.size() != 0), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge c_clk); #1;
    @(posedge c_clk); #1;
    reset = 1'b0;
  endtask

  // Calculator channel model: checks the two request beats, then answers in a chosen WAIT cycle
  initial begin
    model_t m;
    forever begin
      @(negedge c_clk);
      if (!reset && req_cmd_out != 4'd0) begin
        if (model_q.size() == 0) begin
          chk("model_unexpected_issue", 32'(req_cmd_out), 32'd0);
        end else begin
          m = model_q.pop_front();
          chk("send1_cmd", 32'(req_cmd_out), 32'(m.cmd));
          chk("send1_data", req_data_out, m.op1);
          @(negedge c_clk);
          chk("send2_cmd", 32'(req_cmd_out), 32'd0);
          chk("send2_data", req_data_out, m.op2);
          if (m.delay > 0) begin
            repeat (m.delay) @(negedge c_clk);
            chk("wait_bus", {req_data_out[27:0], req_cmd_out}, 32'd0);
            out_resp = m.resp;
            out_data = m.data;
            @(negedge c_clk);
            out_resp = 2'b00;
            out_data = '0;
          end
        end
      end
    end
  end

  // Response monitor: compares each handshaken response against the scoreboard head
  initial begin
    exp_t e;
    forever begin
      @(negedge c_clk);
      if (!reset && rsp_valid && rsp_ready) begin
        if (sb_q.size() == 0) begin
          chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
        end else begin
          e = sb_q.pop_front();
          $display("rsp cmd=%0h resp=%0b data=0x%08h timeout=%0b", rsp_cmd, rsp_resp,
                   rsp_data, rsp_timeout);
          chk("rsp_resp", 32'(rsp_resp), 32'(e.resp));
          chk("rsp_data", rsp_data, e.data);
          chk("rsp_cmd", 32'(rsp_cmd), 32'(e.cmd));
          chk("rsp_timeout", 32'(rsp_timeout), 32'(e.timeout));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got time limit expected $finish earlier");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge c_clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_req_cmd", 32'(req_cmd_out), 32'd0);
    chk("rst_req_data", req_data_out, 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_resp", 32'(rsp_resp), 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_rsp_cmd", 32'(rsp_cmd), 32'd0);
    chk("rst_rsp_timeout", 32'(rsp_timeout), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    @(posedge c_clk); #1;

`ifdef CALC1_SEQ_TIMEOUT_EN
    // Silent calculator: HOLD entered on the 10th WAIT-ending edge (E13)
    rsp_ready = 1'b0;
    add_model(4'd2, 32'd5, 32'd3, 2'b00, 32'd0, 0);
    add_sb(2'b00, 32'd0, 4'd2, 1'b1);
    push(4'd2, 32'd5, 32'd3);
    repeat (12) @(posedge c_clk);
    #1;
    chk("tmo_not_yet", 32'(rsp_valid), 32'd0);
    @(posedge c_clk); #1;
    chk("tmo_valid", 32'(rsp_valid), 32'd1);
    chk("tmo_flag", 32'(rsp_timeout), 32'd1);
    rsp_ready = 1'b1;
    wait_idle("tmo_drain");
`endif

    // Add request, answer in WAIT cycle 3; also checks SEND1/SEND2/WAIT edge timing
    push_timing: begin
      add_model(4'd1, 32'h64, 32'h27, 2'b01, 32'h8B, 3);
      add_sb(2'b01, 32'h0000008B, 4'd1, 1'b0);
      push(4'd1, 32'h64, 32'h27);
      @(posedge c_clk); #1;
      chk("e1_send1_cmd", 32'(req_cmd_out), 32'd1);
      chk("e1_send1_data", req_data_out, 32'h64);
      @(posedge c_clk); #1;
      chk("e2_send2_data", req_data_out, 32'h27);
      @(posedge c_clk); #1;
      chk("e3_wait_data", req_data_out, 32'd0);
      chk("e3_no_rsp", 32'(rsp_valid), 32'd0);
      wait_idle("add_drain");
    end

    // cmd 0 completes locally: HOLD straight after SEND2
    push(4'd0, 32'h11, 32'h22);
    add_sb(2'b00, 32'd0, 4'd0, 1'b0);
    @(posedge c_clk); #1;
    chk("nop_send1_data", req_data_out, 32'h11);
    @(posedge c_clk); #1;
    chk("nop_send2_data", req_data_out, 32'h22);
    chk("nop_send2_valid", 32'(rsp_valid), 32'd0);
    @(posedge c_clk); #1;
    chk("nop_hold_valid", 32'(rsp_valid), 32'd1);
    wait_idle("nop_drain");

    // Unknown command forwarded, resp 11 passed through; then a shift
    issue(4'hF, 32'hAAAA0000, 32'h00005555, 2'b11, 32'hDEADBEEF, 2);
    wait_idle("inv_drain");
    issue(4'd5, 32'd1, 32'd4, 2'b01, 32'h10, 1);
    wait_idle("shl_drain");

    // Backpressure: 5 back-to-back pushes with rsp_ready low, 6th held until a pop
    rsp_ready = 1'b0;
    do_reset();
    issue(4'd1, 32'd1, 32'd2, 2'b01, 32'd3, 1);
    issue(4'd1, 32'd3, 32'd4, 2'b01, 32'd7, 1);
    issue(4'd1, 32'h10, 32'h20, 2'b01, 32'h30, 1);
    issue(4'd1, 32'h100, 32'd1, 2'b01, 32'h101, 1);
    issue(4'd6, 32'h80, 32'd3, 2'b01, 32'h10, 1);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    add_model(4'd2, 32'd9, 32'd4, 2'b01, 32'd5, 1);
    add_sb(2'b01, 32'd5, 4'd2, 1'b0);
    in_valid = 1'b1; in_cmd = 4'd2; in_op1 = 32'd9; in_op2 = 32'd4;
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_resp", 32'(rsp_resp), 32'd1);
      chk("hold_data", rsp_data, 32'd3);
      chk("hold_cmd", 32'(rsp_cmd), 32'd1);
      chk("hold_req_cmd", 32'(req_cmd_out), 32'd0);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      @(posedge c_clk); #1;
    end
    rsp_ready = 1'b1;
    push(4'd2, 32'd9, 32'd4);
    wait_idle("bp_drain");

    // Reset during WAIT; the answer arriving one cycle after the reset edge is ignored
    add_model(4'd1, 32'd7, 32'd8, 2'b01, 32'hF, 2);
    push(4'd1, 32'd7, 32'd8);
    repeat (3) @(posedge c_clk);
    #1;
    reset = 1'b1;
    @(posedge c_clk); #1;
    reset = 1'b0;
    chk("rstw_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rstw_in_ready", 32'(in_ready), 32'd1);
    chk("rstw_busy", 32'(busy), 32'd0);
    chk("rstw_rsp_data", rsp_data, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge c_clk); #1;
      chk("rstw_late_ignored", 32'(rsp_valid || busy), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
